// File: rtl/uart_tx_cfg_pkg.sv
// Package: uart_tx_cfg_pkg
// Shared definitions for the configurable UART serialiser. The future receiver
// is expected to import the same package.
//   tx_state_e            frame FSM states
//   PAR_* / STOP_*        encodings of cfg_parity / cfg_stop
//   DBIT_MIN              narrowest data field supported
//   clamp_dbits()         forces a requested width into DBIT_MIN..max_bits
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // cfg_parity: 2'b11 is treated like PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // cfg_stop: 2'b11 is treated like STOP_2
    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_1P5 = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    localparam int unsigned DBIT_MIN = 5;

    function automatic logic [3:0] clamp_dbits(input logic [3:0] req,
                                               input int unsigned max_bits);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = 4'(DBIT_MIN);
        hi = 4'(max_bits);
        if (req < lo)
            return lo;
        else if (req > hi)
            return hi;
        else
            return req;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Interface: uart_tx_cfg_if
// Request/status bundle between the UART register block (master) and the
// serialiser (slave).
//   tx_start, din, cfg_dbits, cfg_parity, cfg_stop : master -> slave
//   tx_ready, tx_busy, tx_done_tick                : slave -> master
interface uart_tx_cfg_if #(
    parameter int DBIT_MAX = 8
);
    logic                tx_start;
    logic [DBIT_MAX-1:0] din;
    logic [3:0]          cfg_dbits;
    logic [1:0]          cfg_parity;
    logic [1:0]          cfg_stop;
    logic                tx_ready;
    logic                tx_busy;
    logic                tx_done_tick;

    modport master (
        output tx_start, din, cfg_dbits, cfg_parity, cfg_stop,
        input  tx_ready, tx_busy, tx_done_tick
    );

    modport slave (
        input  tx_start, din, cfg_dbits, cfg_parity, cfg_stop,
        output tx_ready, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_cfg_parity.sv
// Module: uart_tx_cfg_parity
// Combinational parity generator shared by transmitter and receiver.
//   data  in  W   data field, bits above the frame width already forced to 0
//   odd   in  1   1 = odd parity, 0 = even parity
//   par   out 1   parity bit to place on the line
// Zeroed upper bits do not disturb the XOR, so the width is only needed by
// whoever does the masking.
module uart_tx_cfg_parity #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         odd,
    output logic         par
);
    assign par = (^data) ^ odd;
endmodule

// File: rtl/uart_tx_cfg.sv
// Module: uart_tx_cfg
// Runtime-configurable UART serialiser: start bit, 5..DBIT_MAX data bits LSB
// first, optional even/odd parity, then 1, 1.5 or 2 stop bits. Every bit period
// is OVS oversample ticks (s_tick) long.
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   s_tick   in   oversample tick from baud_gen, one clk wide
//   bus      slave modport of uart_tx_cfg_if (start/data/config in, status out)
//   dout     out  registered serial line, idle high
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int DBIT_MAX = 8,
    parameter int OVS      = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_tick,
    uart_tx_cfg_if.slave bus,
    output logic         dout
);
    localparam int TW = $clog2(2 * OVS);
    localparam int BW = $clog2(DBIT_MAX);

    localparam logic [TW-1:0] BIT_LAST   = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP1_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVS) / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVS - 1);

    tx_state_e           state_reg;
    logic [TW-1:0]       tick_reg;
    logic [BW-1:0]       bit_reg;
    logic [BW-1:0]       last_bit_reg;
    logic [DBIT_MAX-1:0] shift_reg;
    logic                par_en_reg;
    logic                par_bit_reg;
    logic [TW-1:0]       stop_last_reg;
    logic                dout_reg;
    logic                ready_reg;
    logic                done_reg;

    // Frame parameters derived from the live inputs; only captured on acceptance,
    // which is what makes mid-frame config changes harmless.
    logic [3:0]          dbits_clamped;
    logic [BW-1:0]       last_bit_in;
    logic [DBIT_MAX-1:0] din_masked;
    logic                par_calc;
    logic                par_en_in;
    logic [TW-1:0]       stop_last_in;

    assign dbits_clamped = clamp_dbits(bus.cfg_dbits, DBIT_MAX);
    assign last_bit_in   = BW'(dbits_clamped - 4'd1);
    assign par_en_in     = (bus.cfg_parity == PAR_EVEN) || (bus.cfg_parity == PAR_ODD);

    generate
        for (genvar gi = 0; gi < DBIT_MAX; gi++) begin : g_mask
            assign din_masked[gi] = bus.din[gi] & (4'(gi) < dbits_clamped);
        end
    endgenerate

    uart_tx_cfg_parity #(
        .W (DBIT_MAX)
    ) u_parity (
        .data (din_masked),
        .odd  (bus.cfg_parity == PAR_ODD),
        .par  (par_calc)
    );

    always_comb begin
        stop_last_in = STOP2_LAST;
        case (bus.cfg_stop)
            STOP_1:   stop_last_in = STOP1_LAST;
            STOP_1P5: stop_last_in = STOP15_LAST;
            default:  stop_last_in = STOP2_LAST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            tick_reg      <= '0;
            bit_reg       <= '0;
            last_bit_reg  <= '0;
            shift_reg     <= '0;
            par_en_reg    <= 1'b0;
            par_bit_reg   <= 1'b0;
            stop_last_reg <= '0;
            dout_reg      <= 1'b1;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    dout_reg <= 1'b1;
                    // ready_reg is still 0 in the cycle right after a frame
                    // ends (the done cycle); it rises one edge later.
                    if (ready_reg && bus.tx_start) begin
                        state_reg     <= ST_START;
                        dout_reg      <= 1'b0;
                        ready_reg     <= 1'b0;
                        tick_reg      <= '0;
                        bit_reg       <= '0;
                        shift_reg     <= din_masked;
                        last_bit_reg  <= last_bit_in;
                        par_en_reg    <= par_en_in;
                        par_bit_reg   <= par_calc;
                        stop_last_reg <= stop_last_in;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_LAST) begin
                            tick_reg  <= '0;
                            state_reg <= ST_DATA;
                            dout_reg  <= shift_reg[0];
                        end else begin
                            tick_reg <= tick_reg + TW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_LAST) begin
                            tick_reg <= '0;
                            if (bit_reg == last_bit_reg) begin
                                if (par_en_reg) begin
                                    state_reg <= ST_PARITY;
                                    dout_reg  <= par_bit_reg;
                                end else begin
                                    state_reg <= ST_STOP;
                                    dout_reg  <= 1'b1;
                                end
                            end else begin
                                // Look one bit ahead so dout changes on the boundary edge.
                                bit_reg   <= bit_reg + BW'(1);
                                shift_reg <= shift_reg >> 1;
                                dout_reg  <= shift_reg[1];
                            end
                        end else begin
                            tick_reg <= tick_reg + TW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (s_tick) begin
                        if (tick_reg == BIT_LAST) begin
                            tick_reg  <= '0;
                            state_reg <= ST_STOP;
                            dout_reg  <= 1'b1;
                        end else begin
                            tick_reg <= tick_reg + TW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (s_tick) begin
                        if (tick_reg == stop_last_reg) begin
                            tick_reg  <= '0;
                            state_reg <= ST_IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            tick_reg <= tick_reg + TW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    dout_reg  <= 1'b1;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign dout             = dout_reg;
    assign bus.tx_ready     = ready_reg;
    assign bus.tx_busy      = ~ready_reg;
    assign bus.tx_done_tick = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench: tb_uart_tx_cfg
// Drives uart_tx_cfg with directed and random frames. Expected line levels
// and frame lengths come from a per-frame table built from the framing rules
// (start, clamped data bits LSB first, optional parity, stop length), indexed
// by the number of oversample ticks seen since acceptance. s_tick arrives at
// random spacing of 2..5 clocks to keep run time short.
module tb_uart_tx_cfg;
    localparam int DBIT_MAX = 8;
    localparam int OVS      = 16;

    logic clk;
    logic reset_n;
    logic s_tick;
    logic dout;

    uart_tx_cfg_if #(.DBIT_MAX(DBIT_MAX)) bus ();

    uart_tx_cfg #(
        .DBIT_MAX (DBIT_MAX),
        .OVS      (OVS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick),
        .bus     (bus),
        .dout    (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected line level per bit slot (start, data, parity, then stop = 1).
    bit exp_lvl [0:15];
    int exp_total;

    // Oversample tick source
    int gap = 0;
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            if (gap == 0) begin
                s_tick = 1'b1;
                gap = $urandom_range(1, 4);
            end else begin
                s_tick = 1'b0;
                gap--;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [7:0] d, input int dbits, input int par, input int stp);
        int nd;
        int ones;
        int slot;
        nd   = (dbits < 5) ? 5 : ((dbits > DBIT_MAX) ? DBIT_MAX : dbits);
        ones = 0;
        slot = 0;
        for (int i = 0; i < 16; i++) exp_lvl[i] = 1'b1;
        exp_lvl[slot] = 1'b0;
        slot++;
        for (int i = 0; i < nd; i++) begin
            exp_lvl[slot] = d[i];
            ones += int'(d[i]);
            slot++;
        end
        if (par == 1) begin
            exp_lvl[slot] = (ones % 2) == 1;
            slot++;
        end else if (par == 2) begin
            exp_lvl[slot] = (ones % 2) == 0;
            slot++;
        end
        exp_total = slot * OVS + ((stp == 0) ? OVS : ((stp == 1) ? (3 * OVS) / 2 : 2 * OVS));
    endtask

    // Called #1 after a rising edge. Leaves tx_start high; the frame has been
    // accepted on return (checked via busy and the start bit).
    task automatic start_frame(input logic [7:0] d, input int dbits, input int par, input int stp);
        int w;
        w = 0;
        while (!bus.tx_ready && w < 10) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("ready_before_start", bus.tx_ready, 1);
        bus.din        = d;
        bus.cfg_dbits  = dbits[3:0];
        bus.cfg_parity = par[1:0];
        bus.cfg_stop   = stp[1:0];
        bus.tx_start   = 1'b1;
        model(d, dbits, par, stp);
        @(posedge clk);
        #1;
        check("accept_busy", bus.tx_busy, 1);
        check("start_level", dout, 0);
        $display("frame din=%02h dbits=%0d par=%0d stop=%0d ticks=%0d", d, dbits, par, stp, exp_total);
    endtask

    // Follows one frame tick by tick. Returns #1 after the edge that raised
    // tx_done_tick, or right after an asynchronous reset when abort_at > 0.
    task automatic run_frame(input bit poke, input bit chg, input bit keep_start, input int abort_at);
        int n;
        int cyc;
        bit tk;
        n   = 0;
        cyc = 0;
        if (!keep_start) bus.tx_start = 1'b0;
        while (1) begin
            @(posedge clk);
            tk = s_tick;
            #1;
            cyc++;
            if (cyc > 5000) begin
                check("frame_timeout_ticks", n, exp_total);
                return;
            end
            if (tk) n++;
            check("done_pulse", bus.tx_done_tick, tk && (n == exp_total));
            if (tk && (n % OVS == OVS / 2) && n < exp_total)
                check($sformatf("dout_tick%0d", n), dout, exp_lvl[n / OVS]);
            if (tk && n == exp_total) begin
                check("ready_in_done_cycle", bus.tx_ready, 0);
                check("dout_after_stop", dout, 1);
                return;
            end
            if (abort_at > 0 && tk && n == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("rst_dout", dout, 1);
                check("rst_ready", bus.tx_ready, 1);
                check("rst_busy", bus.tx_busy, 0);
                check("rst_done", bus.tx_done_tick, 0);
                return;
            end
            if (poke)
                bus.tx_start = (n >= 2 * OVS) && (n < 3 * OVS) && (cyc % 3 == 0);
            if (chg && n == 2 * OVS) begin
                bus.din        = 8'($urandom);
                bus.cfg_dbits  = 4'($urandom);
                bus.cfg_parity = 2'($urandom);
                bus.cfg_stop   = 2'($urandom);
            end
        end
    endtask

    task automatic expect_idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("idle_busy", bus.tx_busy, 0);
            check("idle_dout", dout, 1);
        end
    endtask

    task automatic one_frame(input logic [7:0] d, input int dbits, input int par, input int stp);
        start_frame(d, dbits, par, stp);
        run_frame(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.tx_start   = 1'b0;
        bus.din        = '0;
        bus.cfg_dbits  = 4'd8;
        bus.cfg_parity = 2'b00;
        bus.cfg_stop   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", dout, 1);
        check("reset_ready", bus.tx_ready, 1);
        check("reset_busy", bus.tx_busy, 0);
        check("reset_done", bus.tx_done_tick, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames
        one_frame(8'h55, 8, 0, 0);   // 8N1
        one_frame(8'hB5, 7, 1, 0);   // 7E1
        one_frame(8'hFF, 8, 2, 2);   // 8O2
        one_frame(8'hFF, 8, 2, 1);   // 8O, 1.5 stop
        one_frame(8'hFF, 8, 2, 3);   // stop code 11 = two
        one_frame(8'hA6, 3, 1, 0);   // width below minimum -> 5
        one_frame(8'h3C, 15, 3, 0);  // width above maximum -> 8, parity code 11 = none
        one_frame(8'h13, 5, 2, 1);   // narrowest legal frame

        // tx_start pulsed mid-frame: ignored, no second frame
        start_frame(8'h96, 8, 0, 0);
        run_frame(1'b1, 1'b0, 1'b0, 0);
        bus.tx_start = 1'b0;
        expect_idle(40);

        // Config and data changed mid-frame: frame unchanged
        start_frame(8'h4D, 6, 1, 2);
        run_frame(1'b0, 1'b1, 1'b0, 0);

        // tx_start held: back-to-back frames with one ready cycle between
        start_frame(8'h0F, 8, 0, 0);
        run_frame(1'b0, 1'b0, 1'b1, 0);
        @(posedge clk);
        #1;
        check("b2b_ready_gap", bus.tx_ready, 1);
        check("b2b_dout_gap", dout, 1);
        @(posedge clk);
        #1;
        check("b2b_second_busy", bus.tx_busy, 1);
        check("b2b_second_start", dout, 0);
        bus.tx_start = 1'b0;
        run_frame(1'b0, 1'b0, 1'b0, 0);

        // Reset during data bit 3
        start_frame(8'h55, 8, 0, 0);
        run_frame(1'b0, 1'b0, 1'b0, OVS + 3 * OVS + OVS / 2);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("in_reset_done", bus.tx_done_tick, 0);
            check("in_reset_dout", dout, 1);
        end
        reset_n = 1'b1;
        expect_idle(5);
        one_frame(8'h55, 8, 0, 0);

        // Random frames
        for (int k = 0; k < 20; k++) begin
            one_frame(8'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
